// File: rtl/tdm_xbar_router_if.sv
// Source/destination handshake bundle for the TDM crossbar router.
// Router side uses the slave modport; producers/sinks use master.
interface tdm_xbar_router_if #(
  parameter int DATA_W = 4,
  parameter int N_CH   = 4,
  parameter int SEL_W  = 2
);
  logic [N_CH*DATA_W-1:0] src_data;
  logic [N_CH*SEL_W-1:0]  src_dst;
  logic [N_CH-1:0]        src_valid;
  logic [N_CH-1:0]        src_ready;
  logic [N_CH*DATA_W-1:0] dst_data;
  logic [N_CH-1:0]        dst_valid;
  logic [N_CH-1:0]        dst_ready;

  modport slave (
    input  src_data, src_dst, src_valid, dst_ready,
    output src_ready, dst_data, dst_valid
  );

  modport master (
    output src_data, src_dst, src_valid, dst_ready,
    input  src_ready, dst_data, dst_valid
  );
endinterface

// File: rtl/tdm_xbar_router.sv
// N-source to N-destination router over one shared bus with a
// round-robin arbiter and a one-entry output register per destination.
module tdm_xbar_router #(
  parameter int DATA_W = 4,
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  tdm_xbar_router_if.slave     bus,
  output logic [SEL_W-1:0]     grant_id,
  output logic                 grant_vld,
  output logic                 drop_pulse,
  output logic [CNT_W-1:0]     xfer_count,
  output logic                 busy
);

  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(N_CH);

  logic [SEL_W-1:0]       rr_ptr;
  logic [N_CH-1:0]        valid_q;
  logic [N_CH*DATA_W-1:0] data_q;
  logic [N_CH-1:0]        elig;
  logic [N_CH-1:0]        ready_c;
  logic [SEL_W-1:0]       dsel;
  logic [SEL_W-1:0]       j;
  logic [SEL_W-1:0]       win;
  logic                   hit;
  logic [SEL_W-1:0]       win_dst;
  logic [DATA_W-1:0]      win_data;
  logic                   illegal;

  function automatic logic [SEL_W-1:0] wrap(
    input logic [SEL_W-1:0] b,
    input int               k
  );
    int s;
    s = int'(b) + k;
    if (s >= N_CH) s = s - N_CH;
    return s[SEL_W-1:0];
  endfunction

  // A full destination that drains this cycle counts as free.
  always_comb begin
    elig = '0;
    dsel = '0;
    for (int i = 0; i < N_CH; i++) begin
      dsel = bus.src_dst[i*SEL_W +: SEL_W];
      if ({1'b0, dsel} >= NCH)
        elig[i] = en & bus.src_valid[i];
      else
        elig[i] = en & bus.src_valid[i] &
                  (~valid_q[dsel] | bus.dst_ready[dsel]);
    end
  end

  always_comb begin
    hit = 1'b0;
    win = '0;
    j   = '0;
    for (int k = 0; k < N_CH; k++) begin
      j = wrap(rr_ptr, k);
      if (!hit && elig[j]) begin
        hit = 1'b1;
        win = j;
      end
    end
  end

  always_comb begin
    ready_c = '0;
    if (hit && rst_n)
      ready_c = N_CH'(1) << win;
  end

  assign win_dst  = bus.src_dst[win*SEL_W +: SEL_W];
  assign win_data = bus.src_data[win*DATA_W +: DATA_W];
  assign illegal  = ({1'b0, win_dst} >= NCH);

  assign bus.src_ready = ready_c;
  assign bus.dst_valid = valid_q;
  assign bus.dst_data  = data_q;
  assign busy          = |valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      grant_id   <= '0;
      grant_vld  <= 1'b0;
      drop_pulse <= 1'b0;
      xfer_count <= '0;
    end else begin
      grant_vld  <= hit;
      drop_pulse <= hit & illegal;
      if (hit) begin
        rr_ptr   <= wrap(win, 1);
        grant_id <= win;
        if (!illegal)
          xfer_count <= xfer_count + 1'b1;
      end
    end
  end

  // Grant into a destination overrides its drain in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      for (int d = 0; d < N_CH; d++) begin
        if (hit && !illegal && win_dst == SEL_W'(d)) begin
          valid_q[d]                 <= 1'b1;
          data_q[d*DATA_W +: DATA_W] <= win_data;
        end else if (bus.dst_ready[d] && valid_q[d]) begin
          valid_q[d] <= 1'b0;
        end
      end
    end
  end

endmodule
